// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache requests onto a single backing-memory port, one transaction at a time.
// Latency: grant -> resp_valid is 3 cycles for a read, 2 cycles for a write, both with zero-wait memory.
// Backpressure: req_ready is offered only in IDLE; mem_req_* is held until mem_req_ready; nothing is buffered.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ic_req_valid,
    input  logic [31:0] ic_req_addr,
    output logic        ic_req_ready,
    output logic        ic_resp_valid,
    output logic [31:0] ic_resp_data,
    input  logic        dc_req_valid,
    input  logic        dc_req_rw,
    input  logic [31:0] dc_req_addr,
    input  logic [31:0] dc_req_wdata,
    input  logic [3:0]  dc_req_wmask,
    output logic        dc_req_ready,
    output logic        dc_resp_valid,
    output logic [31:0] dc_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        busy,
    output logic        grant_dc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          grant_dc_q, grant_dc_d;
    logic          req_rw_q, req_rw_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   req_wdata_q, req_wdata_d;
    logic [3:0]    req_wmask_q, req_wmask_d;
    logic          ic_resp_valid_q, ic_resp_valid_d;
    logic [31:0]   ic_resp_data_q, ic_resp_data_d;
    logic          dc_resp_valid_q, dc_resp_valid_d;
    logic [31:0]   dc_resp_data_q, dc_resp_data_d;

    logic starve_hit;
    logic dc_win;
    logic ic_win;

    // Winner selection: dcache has priority until icache has watched STARVE_LIMIT dcache grants go by.
    always_comb begin
        starve_hit   = (starve_cnt_q == LIMIT_C);
        dc_win       = dc_req_valid && !(ic_req_valid && starve_hit);
        ic_win       = ic_req_valid && !dc_win;
        ic_req_ready = (state_q == IDLE) && ic_win;
        dc_req_ready = (state_q == IDLE) && dc_win;
    end

    // Starvation counter: counts dcache grants taken while icache waits, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ic_req_valid || ic_req_ready) begin
            starve_cnt_d = '0;
        end else if (dc_req_ready && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // Transaction FSM: latch the winner's payload, hold it to memory, then route the completion back.
    always_comb begin
        state_d         = state_q;
        grant_dc_d      = grant_dc_q;
        req_rw_d        = req_rw_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        req_wmask_d     = req_wmask_q;
        ic_resp_valid_d = 1'b0;
        ic_resp_data_d  = ic_resp_data_q;
        dc_resp_valid_d = 1'b0;
        dc_resp_data_d  = dc_resp_data_q;
        case (state_q)
            IDLE: begin
                if (dc_req_ready) begin
                    state_d     = ISSUE;
                    grant_dc_d  = 1'b1;
                    req_rw_d    = dc_req_rw;
                    req_addr_d  = dc_req_addr;
                    req_wdata_d = dc_req_wdata;
                    req_wmask_d = dc_req_wmask;
                end else if (ic_req_ready) begin
                    state_d     = ISSUE;
                    grant_dc_d  = 1'b0;
                    req_rw_d    = 1'b0;
                    req_addr_d  = ic_req_addr;
                    req_wdata_d = '0;
                    req_wmask_d = '0;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    if (req_rw_q) begin
                        // Writes complete on acceptance; only dcache can issue them.
                        state_d         = IDLE;
                        dc_resp_valid_d = 1'b1;
                        dc_resp_data_d  = '0;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    if (grant_dc_q) begin
                        dc_resp_valid_d = 1'b1;
                        dc_resp_data_d  = mem_resp_data;
                    end else begin
                        ic_resp_valid_d = 1'b1;
                        ic_resp_data_d  = mem_resp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            starve_cnt_q    <= '0;
            grant_dc_q      <= 1'b0;
            req_rw_q        <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_wmask_q     <= '0;
            ic_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_valid_q <= 1'b0;
            dc_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            starve_cnt_q    <= starve_cnt_d;
            grant_dc_q      <= grant_dc_d;
            req_rw_q        <= req_rw_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            req_wmask_q     <= req_wmask_d;
            ic_resp_valid_q <= ic_resp_valid_d;
            ic_resp_data_q  <= ic_resp_data_d;
            dc_resp_valid_q <= dc_resp_valid_d;
            dc_resp_data_q  <= dc_resp_data_d;
        end
    end

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_rw    = req_rw_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;
    assign busy          = (state_q != IDLE);
    assign grant_dc      = grant_dc_q;
    assign ic_resp_valid = ic_resp_valid_q;
    assign ic_resp_data  = ic_resp_data_q;
    assign dc_resp_valid = dc_resp_valid_q;
    assign dc_resp_data  = dc_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level requesters, a behavioural memory and a scoreboard.
// Latency: checks are sampled 1 time unit after each falling edge, inputs change on the falling edge.
// Backpressure: requesters hold each request until accepted; memory inserts random ready/response delays.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ic_req_valid = 1'b0;
    logic [31:0] ic_req_addr = '0;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_data;
    logic        dc_req_valid = 1'b0;
    logic        dc_req_rw = 1'b0;
    logic [31:0] dc_req_addr = '0;
    logic [31:0] dc_req_wdata = '0;
    logic [3:0]  dc_req_wmask = '0;
    logic        dc_req_ready;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        busy;
    logic        grant_dc;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .grant_dc(grant_dc)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          gap;
    } txn_t;

    typedef struct {
        logic ic_v;
        logic dc_v;
        logic exp_ic_rdy;
        logic exp_dc_rdy;
    } arb_vec_t;

    txn_t ic_q[$];
    txn_t dc_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int rst_cycles = 0;

    // Scoreboard: the one transaction in flight and the completions owed to each port.
    bit          outstanding = 0;
    bit          issued = 0;
    bit          cur_dc = 0;
    txn_t        cur;
    bit          ic_due = 0;
    bit          dc_due = 0;
    logic [31:0] ic_due_data = '0;
    logic [31:0] dc_due_data = '0;
    logic [31:0] ic_last = '0;
    logic [31:0] dc_last = '0;
    int          streak = 0;
    int          ic_pulses = 0, dc_pulses = 0;
    int          ic_grant_cyc = 0, dc_grant_cyc = 0, ic_pulse_cyc = 0, dc_pulse_cyc = 0;
    int          issue_cycles = 0, busy_cycles = 0;
    bit          grant_log[$];

    // Behavioural memory.
    logic [31:0] mem_arr [logic [31:0]];
    int          rdy_delay_cfg = 0, resp_delay_cfg = 0;
    bit          rand_delays = 0;
    int          rdy_cnt = 0, resp_cnt = 0;
    bit          read_pending = 0;
    logic [31:0] read_data = '0;
    bit          spur_en = 0, force_spur = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_w(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h6C07_1F3A;
    endfunction

    function automatic int next_delay(input int cfg);
        if (rand_delays) return int'($urandom_range(3, 0));
        return cfg;
    endfunction

    function automatic bit model_pending();
        return outstanding || ic_due || dc_due || (ic_q.size() != 0) || (dc_q.size() != 0);
    endfunction

    task automatic push_ic(input logic [31:0] addr, input int gap);
        txn_t t;
        t.rw = 1'b0; t.addr = addr; t.wdata = '0; t.wmask = '0; t.gap = gap;
        ic_q.push_back(t);
    endtask

    task automatic push_dc(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input int gap);
        txn_t t;
        t.rw = rw; t.addr = addr; t.wdata = wdata; t.wmask = wmask; t.gap = gap;
        dc_q.push_back(t);
    endtask

    task automatic set_mem(input int rdy, input int resp);
        rdy_delay_cfg = rdy; resp_delay_cfg = resp; rdy_cnt = rdy;
    endtask

    task automatic drive_req();
        reset = (rst_cycles > 0);
        if (rst_cycles > 0) rst_cycles--;
        ic_req_valid = 1'b0; ic_req_addr = $urandom;
        dc_req_valid = 1'b0; dc_req_rw = 1'($urandom); dc_req_addr = $urandom;
        dc_req_wdata = $urandom; dc_req_wmask = 4'($urandom);
        if (!reset && ic_q.size() > 0) begin
            if (ic_q[0].gap > 0) ic_q[0].gap = ic_q[0].gap - 1;
            else begin ic_req_valid = 1'b1; ic_req_addr = ic_q[0].addr; end
        end
        if (!reset && dc_q.size() > 0) begin
            if (dc_q[0].gap > 0) dc_q[0].gap = dc_q[0].gap - 1;
            else begin
                dc_req_valid = 1'b1; dc_req_rw = dc_q[0].rw; dc_req_addr = dc_q[0].addr;
                dc_req_wdata = dc_q[0].wdata; dc_req_wmask = dc_q[0].wmask;
            end
        end
    endtask

    task automatic drive_mem();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        if (mem_req_valid === 1'b1) begin
            if (rdy_cnt == 0) mem_req_ready = 1'b1;
            else rdy_cnt--;
        end
        if (read_pending) begin
            if (resp_cnt == 0) begin mem_resp_valid = 1'b1; mem_resp_data = read_data; end
            else resp_cnt--;
        end else if (force_spur || (spur_en && $urandom_range(7, 0) == 0)) begin
            mem_resp_valid = 1'b1; mem_resp_data = $urandom;
        end
    endtask

    task automatic mem_accept();
        logic [31:0] v;
        rdy_cnt = next_delay(rdy_delay_cfg);
        if (mem_req_rw) begin
            v = mem_read(mem_req_addr);
            for (int b = 0; b < 4; b++) if (mem_req_wmask[b]) v[8*b +: 8] = mem_req_wdata[8*b +: 8];
            mem_arr[mem_req_addr] = v;
        end else begin
            read_pending = 1; read_data = mem_read(mem_req_addr);
            resp_cnt = next_delay(resp_delay_cfg);
        end
    endtask

    task automatic monitor();
        bit ic_hs, dc_hs, exp_ic_rdy, exp_dc_rdy;
        if (reset) begin
            if (read_pending && mem_resp_valid) read_pending = 0;
            if (mem_req_valid === 1'b1 && mem_req_ready) mem_accept();
            outstanding = 0; issued = 0; ic_due = 0; dc_due = 0;
            streak = 0; ic_last = '0; dc_last = '0;
            return;
        end
        if (ic_due) begin ic_last = ic_due_data; outstanding = 0; end
        if (dc_due) begin dc_last = dc_due_data; outstanding = 0; end
        chk_b("ic_resp_valid", ic_resp_valid, ic_due);
        chk_b("dc_resp_valid", dc_resp_valid, dc_due);
        chk_w("ic_resp_data", 96'(ic_resp_data), 96'(ic_last));
        chk_w("dc_resp_data", 96'(dc_resp_data), 96'(dc_last));
        if (ic_resp_valid === 1'b1) begin ic_pulses++; ic_pulse_cyc = cyc; end
        if (dc_resp_valid === 1'b1) begin dc_pulses++; dc_pulse_cyc = cyc; end
        ic_due = 0; dc_due = 0;

        exp_dc_rdy = !outstanding && dc_req_valid && !(ic_req_valid && streak >= STARVE_LIMIT);
        exp_ic_rdy = !outstanding && ic_req_valid && !(dc_req_valid && streak < STARVE_LIMIT);
        chk_b("ic_req_ready", ic_req_ready, exp_ic_rdy);
        chk_b("dc_req_ready", dc_req_ready, exp_dc_rdy);
        chk_b("busy", busy, outstanding);
        chk_b("mem_req_valid", mem_req_valid, outstanding && !issued);
        if (outstanding) chk_b("grant_dc", grant_dc, cur_dc);
        if (busy === 1'b1) busy_cycles++;
        if (outstanding && !issued) begin
            issue_cycles++;
            chk_w("mem_req_payload", 96'({mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask}),
                  96'({cur.rw, cur.addr, cur.wdata, cur.wmask}));
        end

        if (read_pending && mem_resp_valid) begin
            read_pending = 0;
            if (outstanding && issued && !cur.rw) begin
                if (cur_dc) begin dc_due = 1; dc_due_data = read_data; end
                else begin ic_due = 1; ic_due_data = read_data; end
            end
        end
        if (mem_req_valid === 1'b1 && mem_req_ready) begin
            mem_accept();
            if (outstanding && !issued) begin
                issued = 1;
                if (cur.rw) begin dc_due = 1; dc_due_data = '0; end
            end
        end

        ic_hs = ic_req_valid && (ic_req_ready === 1'b1);
        dc_hs = dc_req_valid && (dc_req_ready === 1'b1);
        if (ic_hs) begin
            cur = ic_q.pop_front();
            cur.rw = 1'b0; cur.wdata = '0; cur.wmask = '0;
            cur_dc = 0; ic_grant_cyc = cyc;
        end
        if (dc_hs) begin
            cur = dc_q.pop_front();
            cur_dc = 1; dc_grant_cyc = cyc;
        end
        if (ic_hs || dc_hs) begin
            outstanding = 1; issued = 0; grant_log.push_back(dc_hs);
        end
        if (!ic_req_valid || ic_hs) streak = 0;
        else if (dc_hs && streak < STARVE_LIMIT) streak++;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_req();
        drive_mem();
        #1;
        monitor();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (i < budget && model_pending()) begin cycle(); i++; end
        chk_b(name, model_pending(), 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_cycles = n;
        run(n);
        @(posedge clk); #1;
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_grant_dc", grant_dc, 1'b0);
        chk_b("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk_b("rst_ic_resp_valid", ic_resp_valid, 1'b0);
        chk_b("rst_dc_resp_valid", dc_resp_valid, 1'b0);
        chk_w("rst_payload", 96'({mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask}), 96'd0);
        chk_w("rst_resp_data", 96'({ic_resp_data, dc_resp_data}), 96'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t tbl[4];
        bit       exp_pat[15];
        int       b_ic, b_dc;

        tbl[0] = '{ic_v: 1'b0, dc_v: 1'b0, exp_ic_rdy: 1'b0, exp_dc_rdy: 1'b0};
        tbl[1] = '{ic_v: 1'b1, dc_v: 1'b0, exp_ic_rdy: 1'b1, exp_dc_rdy: 1'b0};
        tbl[2] = '{ic_v: 1'b0, dc_v: 1'b1, exp_ic_rdy: 1'b0, exp_dc_rdy: 1'b1};
        tbl[3] = '{ic_v: 1'b1, dc_v: 1'b1, exp_ic_rdy: 1'b0, exp_dc_rdy: 1'b1};
        for (int i = 0; i < 15; i++) exp_pat[i] = ((i % (STARVE_LIMIT + 1)) != STARVE_LIMIT);

        do_reset(2);

        // Single icache read with zero-wait memory.
        mem_arr[32'h100] = 32'hDEAD_BEEF;
        set_mem(0, 0);
        b_ic = ic_pulses; b_dc = dc_pulses;
        push_ic(32'h100, 0);
        wait_idle("d1_done", 20);
        chk_i("d1_latency", ic_pulse_cyc - ic_grant_cyc, 3);
        chk_i("d1_ic_pulses", ic_pulses - b_ic, 1);
        chk_i("d1_dc_pulses", dc_pulses - b_dc, 0);
        chk_w("d1_ic_data", 96'(ic_resp_data), 96'(32'hDEAD_BEEF));

        // dcache write with memory ready delayed by 2 cycles.
        set_mem(2, 0);
        b_ic = ic_pulses; b_dc = dc_pulses; issue_cycles = 0; busy_cycles = 0;
        push_dc(1'b1, 32'h40, 32'h1234_5678, 4'hF, 0);
        wait_idle("d2_done", 20);
        chk_i("d2_issue_cycles", issue_cycles, 3);
        chk_i("d2_busy_cycles", busy_cycles, 3);
        chk_i("d2_dc_pulses", dc_pulses - b_dc, 1);
        chk_i("d2_ic_pulses", ic_pulses - b_ic, 0);
        chk_w("d2_dc_data", 96'(dc_resp_data), 96'd0);
        chk_w("d2_mem_written", 96'(mem_read(32'h40)), 96'(32'h1234_5678));

        // Both ports saturated: dcache may pass icache only STARVE_LIMIT times in a row.
        set_mem(0, 0);
        grant_log.delete();
        for (int i = 0; i < 12; i++) push_dc(1'b1, 32'h1000 + i, 32'hA000_0000 + i, 4'hF, 0);
        for (int i = 0; i < 3; i++) push_ic(32'h2000 + i, 0);
        wait_idle("d3_done", 200);
        chk_i("d3_grants", grant_log.size(), 15);
        for (int i = 0; i < 15 && i < grant_log.size(); i++)
            chk_b($sformatf("d3_grant_%0d", i), grant_log[i], exp_pat[i]);

        // Simultaneous single requests: dcache first, icache in the following IDLE.
        grant_log.delete();
        push_dc(1'b0, 32'h80, 32'h0, 4'h0, 0);
        push_ic(32'h84, 0);
        wait_idle("d4_done", 40);
        chk_i("d4_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk_b("d4_first_dc", grant_log[0], 1'b1);
            chk_b("d4_second_ic", grant_log[1], 1'b0);
        end
        chk_i("d4_spacing", ic_grant_cyc - dc_grant_cyc, 3);

        // Reset while waiting for read data; the late response must vanish.
        set_mem(0, 3);
        push_ic(32'h100, 0);
        for (int i = 0; i < 20 && !read_pending; i++) cycle();
        chk_b("d5_reached_resp", read_pending, 1'b1);
        b_ic = ic_pulses; b_dc = dc_pulses;
        do_reset(1);
        run(6);
        chk_i("d5_ic_pulses", ic_pulses - b_ic, 0);
        chk_i("d5_dc_pulses", dc_pulses - b_dc, 0);
        chk_b("d5_busy", busy, 1'b0);
        set_mem(0, 0);
        push_ic(32'h100, 0);
        wait_idle("d5_next_done", 20);
        chk_i("d5_next_pulses", ic_pulses - b_ic, 1);
        chk_w("d5_next_data", 96'(ic_resp_data), 96'(32'hDEAD_BEEF));

        // Spurious memory response while idle.
        b_ic = ic_pulses; b_dc = dc_pulses;
        force_spur = 1;
        cycle();
        force_spur = 0;
        run(3);
        chk_i("d6_ic_pulses", ic_pulses - b_ic, 0);
        chk_i("d6_dc_pulses", dc_pulses - b_dc, 0);
        chk_w("d6_ic_data", 96'(ic_resp_data), 96'(32'hDEAD_BEEF));
        chk_w("d6_dc_data", 96'(dc_resp_data), 96'd0);

        // Combinational ready vectors in IDLE; valids withdrawn before the edge so nothing is granted.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            ic_req_valid = tbl[i].ic_v; dc_req_valid = tbl[i].dc_v;
            #1;
            chk_b($sformatf("tbl%0d_ic_rdy", i), ic_req_ready, tbl[i].exp_ic_rdy);
            chk_b($sformatf("tbl%0d_dc_rdy", i), dc_req_ready, tbl[i].exp_dc_rdy);
            #1;
            ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        end
        streak = 0;

        // Random traffic against the scoreboard.
        rand_delays = 1; spur_en = 1; rdy_cnt = 0;
        b_ic = ic_pulses; b_dc = dc_pulses;
        for (int i = 0; i < 150; i++) begin
            push_ic(32'h200 + 32'($urandom_range(15, 0)), int'($urandom_range(4, 0)));
            push_dc(1'($urandom), 32'h200 + 32'($urandom_range(15, 0)), $urandom,
                    4'($urandom), int'($urandom_range(4, 0)));
        end
        wait_idle("rand_drained", 20000);
        chk_i("rand_ic_pulses", ic_pulses - b_ic, 150);
        chk_i("rand_dc_pulses", dc_pulses - b_dc, 150);
        spur_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive dcache grants while an icache request waits.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- ic_req_valid  in  1  icache read request
- ic_req_addr  in  32  icache word address
- ic_req_ready  out  1  icache request accepted this cycle
- ic_resp_valid  out  1  icache read data valid, 1-cycle pulse
- ic_resp_data  out  32  icache read data
- dc_req_valid  in  1  dcache request
- dc_req_rw  in  1  1=write, 0=read
- dc_req_addr  in  32  dcache word address
- dc_req_wdata  in  32  write data
- dc_req_wmask  in  4  byte write enables
- dc_req_ready  out  1  dcache request accepted this cycle
- dc_resp_valid  out  1  dcache completion pulse; reads and writes
- dc_resp_data  out  32  dcache read data; 0 for writes
- mem_req_valid  out  1  request to backing memory
- mem_req_ready  in  1  memory accepts request
- mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/32/32/4  latched request payload
- mem_resp_valid  in  1  memory read data valid
- mem_resp_data  in  32  memory read data
- busy  out  1  high in any state other than IDLE
- grant_dc  out  1  owner of the current transaction: 1=dcache, 0=icache

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and RESP; only one memory transaction SHALL be outstanding at a time.
REQ-004 In IDLE, the arbiter SHALL assert exactly one of ic_req_ready or dc_req_ready, combinationally, for the winner among asserted valids; both SHALL be 0 in other states.
REQ-005 The winner SHALL be dcache when both are valid, unless starve_cnt == STARVE_LIMIT, in which case the winner SHALL be icache.
REQ-006 starve_cnt SHALL behave as follows:
- increment on each dcache grant while ic_req_valid=1
- clear on an icache grant, or on any cycle with ic_req_valid=0
- saturate at STARVE_LIMIT
REQ-007 On a grant (valid & ready), the block SHALL latch the payload into mem_req_* and grant_dc, and go to ISSUE; icache payload SHALL be rw=0, wdata=0, wmask=0.
REQ-008 In ISSUE, mem_req_valid SHALL be 1 and mem_req_* SHALL be held stable until mem_req_ready=1; elsewhere mem_req_valid SHALL be 0.
REQ-009 On the ISSUE handshake of a read, the FSM SHALL go to RESP.
REQ-010 On the ISSUE handshake of a write, the FSM SHALL go to IDLE, and dc_resp_valid SHALL pulse the next cycle with dc_resp_data=0.
REQ-011 In RESP, on mem_resp_valid=1, the block SHALL register mem_resp_data into the owner's resp_data, pulse the owner's resp_valid for one cycle starting the next cycle, and go to IDLE.
REQ-012 mem_resp_valid SHALL be ignored outside RESP.
REQ-013 A new grant MAY occur in the same cycle as a resp_valid pulse; minimum grant-to-grant spacing is 3 cycles for reads and 2 cycles for writes with zero-wait memory.
REQ-014 resp_data SHALL hold its value until the next response to the same port.
REQ-015 Requesters SHALL hold valid and payload until ready; the arbiter SHALL NOT buffer unaccepted requests.
REQ-016 With zero-wait memory, read latency from grant to resp_valid SHALL be 3 cycles.

Reset
REQ-017 On reset, the block SHALL force IDLE and clear starve_cnt, all resp_valid, mem_req_valid, busy and grant_dc, and zero all data and payload registers.
REQ-018 A reset mid-transaction SHALL abort the transaction with no resp_valid pulse; any later mem_resp_valid for it SHALL be ignored.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single icache read, addr 0x100, mem ready and resp immediate -> ic_resp_valid 3 cycles after grant with mem data 0xDEADBEEF; dc_resp_valid stays 0.
- dc write addr 0x40, wdata 0x12345678, wmask 0xF, mem_req_ready delayed 2 cycles -> mem_req_* stable for 3 cycles; dc_resp_valid pulses once with data 0; no RESP state entered.
- ic_req_valid and dc_req_valid held high continuously with STARVE_LIMIT=4 -> grant pattern dc,dc,dc,dc,ic repeating.
- Simultaneous single requests from both ports -> dcache granted first, icache on the next IDLE.
- Reset asserted in RESP, then mem_resp_valid arrives -> no resp_valid on either port; busy=0; next request serviced normally.
- Spurious mem_resp_valid in IDLE -> ignored; resp_data unchanged.
